// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Receives a count byte N followed by 4N little-endian bytes over a
// valid/ready link, writes N 32-bit words to addresses 0..N-1, then pulses
// core_start and stays busy until the core raises core_done.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte (CHECK state) and a sticky err flag.
//
// Handshake: a byte moves on a rising edge where in_valid && in_ready are
// both high; in_ready is a registered output and never depends on in_valid.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_start,
  input  logic              core_done,
  output logic              busy,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_START = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_idx;  // index of the final word (N-1, N==0 wraps to all ones)
  logic [ADDR_W-1:0] idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       wbuf;      // first three bytes of the current word
  logic [ADDR_W-1:0] cnt_in;
  logic              accept;

  assign cnt_in    = ADDR_W'(in_data);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Loader FSM with registered handshake, memory-write and core-control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_idx   <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      wbuf       <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            last_idx <= cnt_in - {{(ADDR_W-1){1'b0}}, 1'b1};
            idx      <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (accept) begin
            wbuf     <= {in_data, wbuf[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= idx;
              mem_wdata <= {in_data, wbuf};
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready   <= 1'b1;
            state      <= S_CHECK;
`else
            core_start <= 1'b1;
            state      <= S_START;
`endif
          end else begin
            idx      <= idx + {{(ADDR_W-1){1'b0}}, 1'b1};
            in_ready <= 1'b1;
            state    <= S_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            if (in_data == csum) begin
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              state      <= S_START;
            end else begin
              err_q    <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
`endif
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Drivers push expected (addr, word) pairs into exp_q; a negedge monitor
// pops and compares on every mem_we and counts core_start pulses.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to cover the checksum feature.
module tb_imem_loader;

  localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_start;
  logic              core_done;
  logic              busy;
  logic              err;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int start_count = 0;
  int next_addr = 0;
  logic [7:0] xsum;
  logic [ADDR_W+31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every memory write against the expected queue.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (rst && core_start) start_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
    stalls = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      xsum = xsum ^ b;
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_count(input logic [7:0] n, input int gap, inout int stalls);
    int s;
    send_byte(n, gap, s);
    stalls += s;
    xsum = 8'h00;
    next_addr = 0;
  endtask

  // Send one little-endian word and queue its expected write.
  task automatic send_word(input logic [31:0] w, input int max_gap, inout int stalls);
    int s;
    exp_q.push_back({ADDR_W'(next_addr), w});
    next_addr++;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], (max_gap == 0) ? 0 : $urandom_range(0, max_gap), s);
      if (s > 1) chk("stall_per_byte", 32'(s), 32'd1);
      stalls += s;
    end
  endtask

  task automatic send_checksum(input logic [7:0] c, inout int stalls);
    int s;
    send_byte(c, 0, s);
    stalls += s;
  endtask

  // Wait for the start pulse, hold busy in RUN, then release with core_done.
  task automatic finish_run(input int exp_starts);
    int t;
    t = 0;
    while (start_count < exp_starts && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("start_count", 32'(start_count), 32'(exp_starts));
    repeat (4) begin
      @(negedge clk);
      chk("busy_in_run", 32'(busy), 32'd1);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("ready_after_done", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("single_start", 32'(start_count), 32'(exp_starts));
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic two_word_load(input int max_gap);
    int stalls;
    stalls = 0;
    send_count(8'h02, 0, stalls);
    send_word(32'h0050_0013, max_gap, stalls);
    send_word(32'h0010_0093, max_gap, stalls);
    if (CK == 1) send_checksum(8'hC0, stalls);
    idle_bus();
    if (max_gap == 0) chk("stalls_two_word", 32'(stalls), 32'(1 + CK));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int stalls;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    core_done = 1'b0;
    xsum = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Two-word load, back-to-back bytes.
    two_word_load(0);
    finish_run(1);

    // Same load with random valid gaps; core_done held high while idle is ignored.
    core_done = 1'b1;
    repeat (3) @(negedge clk);
    core_done = 1'b0;
    chk("done_ignored_idle", 32'(busy), 32'd0);
    two_word_load(3);
    finish_run(2);

    // Reset after two data bytes of word 0: no write, no start.
    stalls = 0;
    send_count(8'h02, 0, stalls);
    send_byte(8'h13, 0, stalls);
    send_byte(8'h00, 0, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_starts", 32'(start_count), 32'd2);
    two_word_load(0);
    finish_run(3);

    // Count byte 00: 256 words at addresses 0..255.
    stalls = 0;
    send_count(8'h00, 0, stalls);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      send_word({8'hA5, ~a, a + 8'd1, a}, 0, stalls);
    end
    if (CK == 1) send_checksum(xsum, stalls);
    idle_bus();
    chk("stalls_256", 32'(stalls), 32'(255 + CK));
    finish_run(4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: err set, no start, back to IDLE.
    stalls = 0;
    send_count(8'h02, 0, stalls);
    send_word(32'h0050_0013, 0, stalls);
    send_word(32'h0010_0093, 0, stalls);
    send_checksum(8'hC1, stalls);
    idle_bus();
    repeat (3) @(negedge clk);
    chk("bad_ck_err", 32'(err), 32'd1);
    chk("bad_ck_busy", 32'(busy), 32'd0);
    chk("bad_ck_ready", 32'(in_ready), 32'd1);
    chk("bad_ck_no_start", 32'(start_count), 32'd4);
    chk("bad_ck_writes", 32'(exp_q.size()), 32'd0);
    // Next count byte clears err; finish with a correct load.
    send_count(8'h02, 0, stalls);
    idle_bus();
    chk("err_cleared", 32'(err), 32'd0);
    send_word(32'h0050_0013, 0, stalls);
    send_word(32'h0010_0093, 0, stalls);
    send_checksum(8'hC0, stalls);
    idle_bus();
    finish_run(5);
    chk("good_ck_err", 32'(err), 32'd0);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
